// File: rtl/alu_result_pipe.sv
// ALU result select stage followed by a DEPTH-entry ready/valid FIFO.
// Result and zero flag are captured at acceptance; outputs come from registered head state only.
module alu_result_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_and,
    input  logic [WIDTH-1:0] in_or,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_less,
    input  logic [1:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [CW-1:0]    out_count
);

    typedef enum logic [1:0] {
        SEL_AND = 2'b00,
        SEL_OR  = 2'b01,
        SEL_SUM = 2'b10,
        SEL_SLT = 2'b11
    } sel_e;

    logic [DEPTH-1:0][WIDTH-1:0] res_mem;
    logic [DEPTH-1:0]            zero_mem;
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [CW-1:0]               count;
    logic [WIDTH-1:0]            sel_result;
    logic                        sel_zero;
    logic                        push;
    logic                        pop;

    always_comb begin
        sel_result = '0;
        case (sel_e'(in_sel))
            SEL_AND: sel_result = in_and;
            SEL_OR:  sel_result = in_or;
            SEL_SUM: sel_result = in_sum;
            SEL_SLT: sel_result = {{(WIDTH-1){1'b0}}, in_less};
            default: sel_result = '0;
        endcase
        sel_zero = (sel_result == '0);
    end

    // Handshake qualifiers depend only on registered count, never on the other side's ready.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            res_mem  <= '0;
            zero_mem <= '0;
        end else begin
            if (push) begin
                res_mem[wr_ptr]  <= sel_result;
                zero_mem[wr_ptr] <= sel_zero;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_result = res_mem[rd_ptr];
    assign out_zero   = zero_mem[rd_ptr];
    assign out_count  = count;

endmodule

// File: tb/tb_alu_result_pipe.sv
// Directed bench for alu_result_pipe: DEPTH=2 instance for select/fill/concurrency/reset,
// DEPTH=3 instance for pointer wrap under output stalls.
module tb_alu_result_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_valid = 0, a_out_ready = 0, a_in_less = 0;
    logic [1:0]  a_in_sel = 0;
    logic [31:0] a_in_and = 0, a_in_or = 0, a_in_sum = 0;
    logic        a_in_ready, a_out_valid, a_out_zero;
    logic [31:0] a_out_result;
    logic [1:0]  a_out_count;

    logic        b_in_valid = 0, b_out_ready = 0;
    logic [31:0] b_in_sum = 0;
    logic        b_in_ready, b_out_valid, b_out_zero;
    logic [31:0] b_out_result;
    logic [1:0]  b_out_count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_result_pipe #(.WIDTH(32), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_and(a_in_and), .in_or(a_in_or), .in_sum(a_in_sum),
        .in_less(a_in_less), .in_sel(a_in_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_result(a_out_result), .out_zero(a_out_zero), .out_count(a_out_count)
    );

    alu_result_pipe #(.WIDTH(32), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_and(32'h0), .in_or(32'h0), .in_sum(b_in_sum),
        .in_less(1'b0), .in_sel(2'b10),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_out_result), .out_zero(b_out_zero), .out_count(b_out_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks happen 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [31:0] an,
                           input logic [31:0] o, input logic [31:0] s, input logic l);
        @(negedge clk);
        a_in_valid = v; a_in_sel = sel; a_in_and = an; a_in_or = o; a_in_sum = s; a_in_less = l;
    endtask

    logic [3:0] stall_pat [0:15] = '{0,1,1,0,1,0,0,1,1,1,0,1,0,0,1,1};

    initial begin
        int sent, got, cyc;
        logic do_push, do_pop;

        // Reset state
        #2;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_count",     64'(a_out_count), 64'd0);
        check("rst_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_result",    64'(a_out_result), 64'd0);
        check("rst_zero",      64'(a_out_zero),  64'd0);
        @(negedge clk); rst = 1'b0;

        // Select: stream one per cycle with out_ready=1; each lands at head after its edge
        a_out_ready = 1'b1;
        drive_a(1, 2'b00, 32'h0F0F0F0F, 32'hFFFF0000, 32'h0, 1); step();
        check("sel_and_res",  64'(a_out_result), 64'h0F0F0F0F);
        check("sel_and_zero", 64'(a_out_zero), 64'd0);
        check("sel_and_vld",  64'(a_out_valid), 64'd1);
        drive_a(1, 2'b01, 32'h0F0F0F0F, 32'hFFFF0000, 32'h0, 1); step();
        check("sel_or_res",   64'(a_out_result), 64'hFFFF0000);
        check("sel_or_zero",  64'(a_out_zero), 64'd0);
        drive_a(1, 2'b10, 32'h0F0F0F0F, 32'hFFFF0000, 32'h0, 1); step();
        check("sel_sum_res",  64'(a_out_result), 64'h0);
        check("sel_sum_zero", 64'(a_out_zero), 64'd1);
        drive_a(1, 2'b11, 32'h0F0F0F0F, 32'hFFFF0000, 32'h0, 1); step();
        check("sel_slt_res",  64'(a_out_result), 64'h1);
        check("sel_slt_zero", 64'(a_out_zero), 64'd0);
        check("sel_count",    64'(a_out_count), 64'd1);
        drive_a(0, 2'b00, 32'h0, 32'h0, 32'h0, 0); step();
        check("sel_drained",  64'(a_out_count), 64'd0);

        // Fill: three pushes into DEPTH=2 with consumer stalled
        @(negedge clk); a_out_ready = 1'b0;
        drive_a(1, 2'b00, 32'h11111111, 32'h0, 32'h0, 0); step();
        drive_a(1, 2'b00, 32'h22222222, 32'h0, 32'h0, 0); step();
        check("fill_count2",   64'(a_out_count), 64'd2);
        check("fill_in_ready", 64'(a_in_ready), 64'd0);
        drive_a(1, 2'b00, 32'h33333333, 32'h0, 32'h0, 0); step();
        check("fill_count3",   64'(a_out_count), 64'd2);
        check("fill_head",     64'(a_out_result), 64'h11111111);
        check("fill_hold_vld", 64'(a_out_valid), 64'd1);

        // Concurrent: full, so first edge is pop only; next edge is push+pop
        @(negedge clk); a_out_ready = 1'b1;
        a_in_valid = 1; a_in_and = 32'h44444444;
        step();
        check("conc_pop_count", 64'(a_out_count), 64'd1);
        check("conc_pop_head",  64'(a_out_result), 64'h22222222);
        check("conc_in_ready",  64'(a_in_ready), 64'd1);
        drive_a(1, 2'b00, 32'h55555555, 32'h0, 32'h0, 0); step();
        check("conc_pp_count",  64'(a_out_count), 64'd1);
        check("conc_pp_head",   64'(a_out_result), 64'h55555555);
        drive_a(0, 2'b00, 32'h0, 32'h0, 32'h0, 0); step();
        check("conc_drained",   64'(a_out_count), 64'd0);

        // SLT is zero-extended flag, not the sum
        drive_a(1, 2'b11, 32'h0, 32'h0, 32'hFFFFFFFF, 0); step();
        check("slt_w_res",  64'(a_out_result), 64'h0);
        check("slt_w_zero", 64'(a_out_zero), 64'd1);
        drive_a(0, 2'b00, 32'h0, 32'h0, 32'h0, 0); step();

        // Mid-stream async reset with count=2
        @(negedge clk); a_out_ready = 1'b0;
        drive_a(1, 2'b01, 32'h0, 32'hABCD0001, 32'h0, 0); step();
        drive_a(1, 2'b01, 32'h0, 32'hABCD0002, 32'h0, 0); step();
        check("mid_pre_count", 64'(a_out_count), 64'd2);
        drive_a(0, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_vld",    64'(a_out_valid), 64'd0);
        check("mid_rst_count",  64'(a_out_count), 64'd0);
        check("mid_rst_ready",  64'(a_in_ready), 64'd1);
        check("mid_rst_result", 64'(a_out_result), 64'd0);
        @(negedge clk); rst = 1'b0;
        a_in_valid = 1; a_in_sel = 2'b01; a_in_or = 32'hCAFEF00D;
        step();
        check("post_rst_count", 64'(a_out_count), 64'd1);
        check("post_rst_head",  64'(a_out_result), 64'hCAFEF00D);
        @(negedge clk); a_in_valid = 0;

        // Wrap on DEPTH=3: 10 items, patterned stalls, in-order scoreboard
        sent = 0; got = 0; cyc = 0;
        while (got < 10 && cyc < 300) begin
            @(negedge clk);
            b_in_valid  = (sent < 10);
            b_in_sum    = 32'hA0000000 + 32'(sent);
            b_out_ready = ~stall_pat[cyc % 16][0];
            #1;
            do_push = b_in_valid && b_in_ready;
            do_pop  = b_out_valid && b_out_ready;
            if (do_pop) begin
                check($sformatf("wrap_item%0d", got), 64'(b_out_result), 64'(32'hA0000000 + 32'(got)));
                got++;
            end
            if (do_push) sent++;
            cyc++;
        end
        @(negedge clk); b_in_valid = 0; b_out_ready = 0;
        check("wrap_delivered", 64'(got), 64'd10);
        check("wrap_empty",     64'(b_out_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_result_pipe.md
ALU_RESULT_PIPE -- requirements
Module: alu_result_pipe

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits, legal range 4..64.
REQ-002 Parameter DEPTH, default 2: output buffer entries, legal range 2..8.
REQ-003 Port clk  in  1: single clock, all state updates on the rising edge.
REQ-004 Port rst  in  1: reset, asynchronous, active-high.
REQ-005 Port in_valid  in  1: the operand set on the in_* ports is valid.
REQ-006 Port in_ready  out  1: the block accepts an operand set this cycle.
REQ-007 Port in_and  in  WIDTH: bitwise-AND result.
REQ-008 Port in_or  in  WIDTH: bitwise-OR result.
REQ-009 Port in_sum  in  WIDTH: adder result.
REQ-010 Port in_less  in  1: set-less-than flag.
REQ-011 Port in_sel  in  2: select code; 00 AND, 01 OR, 10 SUM, 11 SLT.
REQ-012 Port out_valid  out  1: the out_* ports hold a valid result.
REQ-013 Port out_ready  in  1: the consumer takes the result this cycle.
REQ-014 Port out_result  out  WIDTH: selected result.
REQ-015 Port out_zero  out  1: high when out_result is all zeros.
REQ-016 Port out_count  out  clog2(DEPTH+1): number of occupied buffer entries.

Function
REQ-017 Result selection: sel 00 gives in_and, 01 gives in_or, 10 gives in_sum, 11 gives {WIDTH-1 zeros, in_less}, the 1-bit flag zero-extended.
REQ-018 The selected result and its zero flag are computed at acceptance and stored; out_zero is never recomputed from later inputs.
REQ-019 Accept (push) happens when in_valid and in_ready are both high on a clock edge; deliver (pop) happens when out_valid and out_ready are both high on a clock edge.
REQ-020 Storage is a FIFO of DEPTH entries; results leave in acceptance order.
REQ-021 Latency: an item pushed into an empty buffer on edge N has out_valid high after edge N; there is no combinational in-to-out path.
REQ-022 in_ready = (count < DEPTH); it depends only on registered state, not on out_ready.
REQ-023 out_valid = (count != 0); out_result and out_zero reflect the head entry.
REQ-024 Simultaneous push and pop: count unchanged; the head advances and the new item is written at the tail.
REQ-025 Full (count == DEPTH): in_ready is low and no push occurs; a pop on that edge drops count to DEPTH-1, and in_ready rises the next cycle.
REQ-026 Empty (count == 0): out_valid is low; out_ready is ignored and no pop occurs.
REQ-027 Read and write pointers wrap modulo DEPTH, including for non-power-of-2 DEPTH.
REQ-028 out_result and out_zero hold stable while out_valid is high and out_ready is low.
REQ-029 in_* data is ignored when in_valid is low; out_* data is don't-care when out_valid is low but must not be X after reset.

Reset
REQ-030 Asserting rst immediately clears count, both pointers, out_valid, out_result and out_zero; all are 0 and in_ready is 1 (DEPTH > 0).
REQ-031 A push or pop in flight on the edge where rst asserts is discarded; buffered data is lost.
REQ-032 The first push is accepted on the first rising edge after rst deasserts.

Verification
REQ-033 Reset: assert rst mid-stream with count=2 -> out_valid=0, out_count=0, in_ready=1 with no clock edge.
REQ-034 Select: WIDTH=32, and=0x0F0F0F0F, or=0xFFFF0000, sum=0x00000000, less=1; sel 00/01/10/11 in turn with out_ready=1 -> 0x0F0F0F0F/z0, 0xFFFF0000/z0, 0x00000000/z1, 0x00000001/z0, each one cycle after push.
REQ-035 Fill: out_ready=0, push 3 items with DEPTH=2 -> first two accepted, in_ready=0 on the third, out_count=2, head unchanged.
REQ-036 Concurrent: count=2; in_valid=1 and out_ready=1 on one edge -> pop only, count=1; next edge push+pop -> count stays 1, FIFO order preserved.
REQ-037 Wrap: DEPTH=3, stream 10 items with random out_ready stalls -> all 10 delivered in order, none dropped or duplicated.
REQ-038 SLT width: sel=11, in_less=0, in_sum=0xFFFFFFFF -> out_result=0x00000000 and out_zero=1.
